// File: rtl/ttt_pkg.sv
// ttt_pkg: shared types, constants and small coordinate helpers for the
// tic-tac-toe move controller and its button front end.
package ttt_pkg;

   typedef logic [1:0] player_t;
   typedef logic [1:0] coord_t;

   localparam player_t PLAYER0 = 2'd0;
   localparam player_t PLAYER1 = 2'd1;
   localparam player_t EMPTY   = 2'd3;
   localparam int      BOARD_N = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      SETTLE = 2'd2,
      DONE   = 2'd3
   } ctrl_state_t;

   // Linear cell number y*3+x used to index the occupancy map.
   function automatic logic [3:0] cell_idx(input coord_t x, input coord_t y);
      return ({2'b00, y} * 4'(BOARD_N)) + {2'b00, x};
   endfunction

   // Step a coordinate forward, wrapping 2 -> 0.
   function automatic coord_t coord_inc(input coord_t c);
      return (c == coord_t'(BOARD_N - 1)) ? 2'd0 : c + 2'd1;
   endfunction

   // Step a coordinate backward, wrapping 0 -> 2.
   function automatic coord_t coord_dec(input coord_t c);
      return (c == 2'd0) ? coord_t'(BOARD_N - 1) : c - 2'd1;
   endfunction

endpackage

// File: rtl/ttt_btn_edge.sv
// ttt_btn_edge: one button input. Optional debounce filter (enabled with
// the TTT_DEBOUNCE_EN macro) followed by a rising-edge detector that yields
// a single-cycle press per button press, never auto-repeating.
module ttt_btn_edge
   import ttt_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   output logic press
);

   logic level;
   logic prev;

`ifdef TTT_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          filt;
   logic [CW-1:0] cnt;

   // Filtered level follows the raw level only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         filt <= 1'b1;
         cnt  <= '0;
      end else if (btn == filt) begin
         cnt  <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
         filt <= btn;
         cnt  <= '0;
      end else begin
         cnt  <= cnt + 1'b1;
      end
   end

   assign level = filt;
`else
   localparam int unused_debounce = DEBOUNCE_CYCLES;

   assign level = btn;
`endif

   // History starts at 1 so a button held through reset never produces a press.
   always_ff @(posedge clk) begin
      if (!reset_n) prev <= 1'b1;
      else          prev <= level;
   end

   assign press = level & ~prev;

endmodule

// File: rtl/ttt_move_ctrl.sv
// ttt_move_ctrl: button-driven cursor and move issuer in front of the
// tic-tac-toe core. Only legal moves reach the core (free cell, alternating
// player); game end is tracked from stop_game/winner and a new-game button
// restarts both this block and the core. Build with TTT_DEBOUNCE_EN to
// debounce the six button inputs.
//
// Move handshake: enable is a one-cycle strobe with no back-pressure from the
// core; data_in_x, data_in_y and player are valid exactly while enable=1 and
// the core must capture them on that cycle's rising edge.
module ttt_move_ctrl
   import ttt_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int FIRST_PLAYER    = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_sel,
   input  logic       btn_new,
   input  logic       stop_game,
   input  logic [1:0] winner,
   output logic       enable,
   output logic [1:0] data_in_x,
   output logic [1:0] data_in_y,
   output logic [1:0] player,
   output logic       game_rst,
   output logic [1:0] cursor_x,
   output logic [1:0] cursor_y,
   output logic       move_rej,
   output logic       game_over,
   output logic [1:0] last_winner
);

   localparam player_t FIRST_P = (FIRST_PLAYER == 1) ? PLAYER1 : PLAYER0;

   localparam int B_UP    = 0;
   localparam int B_DOWN  = 1;
   localparam int B_LEFT  = 2;
   localparam int B_RIGHT = 3;
   localparam int B_SEL   = 4;
   localparam int B_NEW   = 5;

   logic [5:0]  raw;
   logic [5:0]  press;

   ctrl_state_t state;
   ctrl_state_t state_nx;
   coord_t      cur_x, cur_y;
   coord_t      lat_x, lat_y;
   player_t     next_player;
   player_t     win_q;
   logic [8:0]  occ;
   logic        rej_q;
   logic        rst_q;

   logic        new_p;
   logic        sel_idle;
   logic        cell_busy;
   logic        accept;

   assign raw = {btn_new, btn_sel, btn_right, btn_left, btn_down, btn_up};

   for (genvar i = 0; i < 6; i++) begin : g_btn
      ttt_btn_edge #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
         .clk     (clk),
         .reset_n (reset_n),
         .btn     (raw[i]),
         .press   (press[i])
      );
   end

   // New game overrides everything; a select only counts in IDLE.
   assign new_p     = press[B_NEW];
   assign sel_idle  = press[B_SEL] & ~new_p & (state == IDLE);
   assign cell_busy = occ[cell_idx(cur_x, cur_y)];
   assign accept    = sel_idle & ~cell_busy;

   // Cursor: one direction per cycle, up > down > left > right, wrapping mod 3.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cur_x <= 2'd0;
         cur_y <= 2'd0;
      end else if (press[B_UP]) begin
         cur_y <= coord_dec(cur_y);
      end else if (press[B_DOWN]) begin
         cur_y <= coord_inc(cur_y);
      end else if (press[B_LEFT]) begin
         cur_x <= coord_dec(cur_x);
      end else if (press[B_RIGHT]) begin
         cur_x <= coord_inc(cur_x);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // Next state: ISSUE and SETTLE are single cycles; SETTLE samples the core's verdict.
   always_comb begin
      state_nx = state;
      if (new_p) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state_nx = ISSUE;
            ISSUE:   state_nx = SETTLE;
            SETTLE:  state_nx = stop_game ? DONE : IDLE;
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // State-decoded outputs.
   always_comb begin
      enable    = (state == ISSUE);
      game_over = (state == DONE);
   end

   // Game data: latched move, occupancy, whose turn, latched winner.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lat_x       <= 2'd0;
         lat_y       <= 2'd0;
         occ         <= '0;
         next_player <= FIRST_P;
         win_q       <= EMPTY;
      end else if (new_p) begin
         occ         <= '0;
         next_player <= FIRST_P;
         win_q       <= EMPTY;
      end else begin
         if (accept) begin
            lat_x <= cur_x;
            lat_y <= cur_y;
         end
         if (state == ISSUE) begin
            occ[cell_idx(lat_x, lat_y)] <= 1'b1;
            next_player <= (next_player == PLAYER0) ? PLAYER1 : PLAYER0;
         end
         if ((state == SETTLE) && stop_game) begin
            win_q <= winner;
         end
      end
   end

   // One-cycle pulses: reject on an occupied cell, core restart on reset or new game.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rej_q <= 1'b0;
         rst_q <= 1'b1;
      end else begin
         rej_q <= sel_idle & cell_busy;
         rst_q <= new_p;
      end
   end

   assign data_in_x   = lat_x;
   assign data_in_y   = lat_y;
   assign player      = next_player;
   assign game_rst    = rst_q;
   assign move_rej    = rej_q;
   assign cursor_x    = cur_x;
   assign cursor_y    = cur_y;
   assign last_winner = win_q;

endmodule

// File: doc/ttt_move_ctrl.md
Name: ttt_move_ctrl

Overview:
- Upstream input stage for the tic-tac-toe game core.
- Turns raw button levels (up/down/left/right/select/new-game) into a cursor on the 3x3 board.
- Issues one-cycle move requests (enable, x, y, player) that are always legal for the core: alternating player, free cell, in-range coordinates.
- Watches the core's stop_game/winner and issues a game-restart pulse to the core.

Parameters:
- DEBOUNCE_CYCLES, 16, stable-level cycles required before a button counts (used only with TTT_DEBOUNCE_EN).
- FIRST_PLAYER, 0, player (0 or 1) who moves first after reset or new game.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw button levels, active-high, already synchronous to clk.
- btn_sel  in  1  place mark at cursor.
- btn_new  in  1  start new game.
- stop_game  in  1  from core: game finished.
- winner  in  2  from core: 0/1 winner, 3 = draw/none.
- enable  out  1  one-cycle move strobe to core.
- data_in_x, data_in_y  out  2 each  move coordinates, valid while enable=1.
- player  out  2  mover id, valid while enable=1.
- game_rst  out  1  active-high one-cycle restart pulse to core's reset.
- cursor_x, cursor_y  out  2 each  current cursor, always 0..2.
- move_rej  out  1  one-cycle pulse: select on an occupied cell.
- game_over  out  1  level: controller in DONE.
- last_winner  out  2  winner latched on entry to DONE.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset_n).
- Reset (reset_n=0 at a clk edge) gives:
  - enable=0, game_rst=1 for the following cycle (core is reset together with this block), move_rej=0.
  - cursor=(0,0), next player=FIRST_PLAYER, occupancy map all free, game_over=0, last_winner=3, state=IDLE.
  - Button history registers = 1, so buttons held through reset do not fire.
- Edge detect: press = level & ~prev; one event per press, no auto-repeat.
- Cursor:
  - up: y-1; down: y+1; left: x-1; right: x+1.
  - Wrap modulo 3 (0 <-> 2); never 3.
  - Several direction edges in one cycle: only the highest-priority one applies (up > down > left > right).
  - Cursor moves in every state.
- FSM states: IDLE, ISSUE, SETTLE, DONE.
  - IDLE, select edge, cell free: go to ISSUE, latching the cursor as it was before any same-cycle direction move.
  - IDLE, select edge, cell occupied: move_rej=1 next cycle, stay in IDLE.
  - ISSUE (1 cycle):
    - enable=1 with the latched x/y and current player.
    - Mark the cell occupied and toggle player (0<->1).
    - Go to SETTLE.
  - SETTLE (1 cycle, lets the core register stop_game): if stop_game=1 go to DONE and latch winner into last_winner, else go to IDLE.
  - DONE: game_over=1, select ignored (no move_rej), enable never asserted.
- Latency: select edge at cycle N gives enable high during cycle N+1 only; the next move is accepted no earlier than cycle N+3.
- New game: a btn_new edge in any state, highest priority, has this effect next cycle:
  - game_rst=1 for one cycle; occupancy cleared; player=FIRST_PLAYER; state=IDLE; game_over=0; last_winner=3; cursor unchanged.
  - An enable pending in the same cycle is cancelled.
- All nine cells occupied without stop_game: cannot occur with a correct core; the block stays in IDLE and every select gets move_rej.
- enable and game_rst are never high in the same cycle.

Optional Feature:
- Macro: TTT_DEBOUNCE_EN.
- Defined: each of the six buttons passes through a saturating counter. The filtered level changes only after the raw level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Edge detect runs on the filtered level, so latency grows by DEBOUNCE_CYCLES.
- Undefined: raw levels feed edge detect directly; DEBOUNCE_CYCLES is unused.

Decomposition:
- Package ttt_pkg holds:
  - typedef player_t (logic [1:0]); constants PLAYER0=0, PLAYER1=1, EMPTY=3, BOARD_N=3.
  - typedef coord_t (logic [1:0]).
  - enum ctrl_state_t {IDLE, ISSUE, SETTLE, DONE}.
- One sub-module, ttt_btn_edge: per-button optional debounce plus rising-edge detect, instantiated six times.

Test Plan:
- Reset, then right, right, right, down -> cursor (0,0)->(1,0)->(2,0)->(0,0)->(0,1), no enable.
- Cursor (1,1), select at cycle N -> enable=1 only in N+1 with x=1, y=1, player=0; next select at (0,0) -> player=1.
- Select twice on (2,2) -> first gives enable; second gives move_rej=1 for one cycle, no enable.
- Moves (0,0)P0, (0,1)P1, (1,0)P0, (1,1)P1, (2,0)P0 with a core model -> stop_game, game_over=1, last_winner=0; further selects give no enable.
- btn_new in DONE -> game_rst one cycle, occupancy clear, next move has player=FIRST_PLAYER; up+left in the same cycle -> only y changes.
- With TTT_DEBOUNCE_EN, DEBOUNCE_CYCLES=4, a 3-cycle glitch on btn_sel -> no enable; a 6-cycle press -> exactly one enable.
